// File: rtl/br_pkg.sv
// Shared types and helpers for the miniRISC branch unit: condition codes and BHT counter states.
// Latency: n/a (package only).
// Backpressure: n/a.
package br_pkg;

  typedef enum logic [2:0] {
    COND_NEVER  = 3'b000,
    COND_ALWAYS = 3'b001,
    COND_BZ     = 3'b010,
    COND_BNZ    = 3'b011,
    COND_BLTZ   = 3'b100,
    COND_BGEZ   = 3'b101,
    COND_BCY    = 3'b110,
    COND_BNCY   = 3'b111
  } cond_e;

  // 2-bit saturating counter states; bit 1 is the taken prediction
  localparam logic [1:0] SNT       = 2'b00;
  localparam logic [1:0] WNT       = 2'b01;
  localparam logic [1:0] WT        = 2'b10;
  localparam logic [1:0] ST        = 2'b11;
  localparam logic [1:0] BHT_RESET = WNT;

  // Next counter value after a resolved outcome, saturating at both ends
  function automatic logic [1:0] sat_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == ST) ? ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Branch condition decider: evaluates one of 8 condition codes against an ALU result and carry.
// Latency: purely combinational.
// Backpressure: none; output follows inputs every cycle.
module br_cond_eval
  import br_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        cond,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              carry,
  output logic              taken
);

  logic w_zero;
  logic w_neg;

  assign w_zero = (alu_result == '0);
  assign w_neg  = alu_result[DATA_W-1];

  // Map the condition code onto the zero/sign/carry tests
  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      COND_NEVER:  taken = 1'b0;
      COND_ALWAYS: taken = 1'b1;
      COND_BZ:     taken = w_zero;
      COND_BNZ:    taken = ~w_zero;
      COND_BLTZ:   taken = w_neg;
      COND_BGEZ:   taken = ~w_neg;
      COND_BCY:    taken = carry;
      COND_BNCY:   taken = ~carry;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: BHT-based fetch prediction plus execute-stage resolve with registered verdict.
// Latency: pred_taken combinational; br_taken/mispredict/resolve_done one cycle after resolve_valid.
// Backpressure: none; a resolve is accepted every cycle. Optional BRP_PERF_CNT_EN adds perf counters.
module branch_predict_resolve
  import br_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int PC_LSB = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pred_req,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_taken,
  input  logic              resolve_valid,
  input  logic [PC_W-1:0]   resolve_pc,
  input  logic              resolve_pred_taken,
  input  logic [2:0]        resolve_cond,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              carry_in,
  input  logic              carry_we,
  output logic              br_taken,
  output logic              mispredict,
  output logic              resolve_done
`ifdef BRP_PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
`endif
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [1:0]       r_bht [DEPTH];
  logic             r_carry;
  logic             r_br_taken;
  logic             r_mispredict;
  logic             r_resolve_done;

  logic [IDX_W-1:0] w_pred_idx;
  logic [IDX_W-1:0] w_res_idx;
  logic             w_carry_eff;
  logic             w_cond_taken;
  logic             w_is_cond;
  logic             w_unused;

  // Upper and sub-word PC bits do not take part in indexing; aliasing PCs share an entry
  assign w_unused   = ^{pred_pc, resolve_pc};
  assign w_pred_idx = pred_pc[PC_LSB +: IDX_W];
  assign w_res_idx  = resolve_pc[PC_LSB +: IDX_W];

  // No bypass from a same-cycle update: the prediction reflects the stored counter
  assign pred_taken = pred_req & r_bht[w_pred_idx][1];

  // A carry written in the resolve cycle is visible to that resolve
  assign w_carry_eff = carry_we ? carry_in : r_carry;
  assign w_is_cond   = (resolve_cond[2:1] != 2'b00);

  br_cond_eval #(
    .DATA_W(DATA_W)
  ) u_cond_eval (
    .cond      (resolve_cond),
    .alu_result(alu_result),
    .carry     (w_carry_eff),
    .taken     (w_cond_taken)
  );

  // Carry flag register, written independently of resolve_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry <= 1'b0;
    end else if (carry_we) begin
      r_carry <= carry_in;
    end
  end

  // Registered verdict; gating with resolve_valid keeps idle-cycle X out of the flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_taken     <= 1'b0;
      r_mispredict   <= 1'b0;
      r_resolve_done <= 1'b0;
    end else begin
      r_resolve_done <= resolve_valid;
      r_br_taken     <= resolve_valid & w_cond_taken;
      r_mispredict   <= resolve_valid & (w_cond_taken ^ resolve_pred_taken);
    end
  end

  // BHT training on conditional branches only; NEVER/ALWAYS carry no history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_bht[i] <= BHT_RESET;
      end
    end else if (resolve_valid && w_is_cond) begin
      r_bht[w_res_idx] <= sat_next(r_bht[w_res_idx], w_cond_taken);
    end
  end

  assign br_taken     = r_br_taken;
  assign mispredict   = r_mispredict;
  assign resolve_done = r_resolve_done;

`ifdef BRP_PERF_CNT_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispred;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else begin
      if (resolve_valid) r_perf_branches <= r_perf_branches + 32'd1;
      if (r_mispredict)  r_perf_mispred  <= r_perf_mispred + 32'd1;
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_mispred  = r_perf_mispred;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench for branch_predict_resolve with DATA_W=16, DEPTH=16, PC_LSB=2.
// Latency: checks pred_taken mid-cycle and registered outputs 1 time unit after each edge.
// Backpressure: n/a; inputs are driven every cycle.
module tb_branch_predict_resolve;

  localparam int DATA_W = 16;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 16;
  localparam int PC_LSB = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pred_req;
  logic [PC_W-1:0]   pred_pc;
  logic              pred_taken;
  logic              resolve_valid;
  logic [PC_W-1:0]   resolve_pc;
  logic              resolve_pred_taken;
  logic [2:0]        resolve_cond;
  logic [DATA_W-1:0] alu_result;
  logic              carry_in;
  logic              carry_we;
  logic              br_taken;
  logic              mispredict;
  logic              resolve_done;
`ifdef BRP_PERF_CNT_EN
  logic [31:0]       perf_branches;
  logic [31:0]       perf_mispred;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference state: counters as plain integers 0..3, carry as a bit
  int m_bht [DEPTH];
  bit m_carry;
  int m_pb;
  int m_pm;
  bit m_last_mis;

  always #5 clk = ~clk;

  branch_predict_resolve #(
    .DATA_W(DATA_W), .PC_W(PC_W), .DEPTH(DEPTH), .PC_LSB(PC_LSB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pred_req          (pred_req),
    .pred_pc           (pred_pc),
    .pred_taken        (pred_taken),
    .resolve_valid     (resolve_valid),
    .resolve_pc        (resolve_pc),
    .resolve_pred_taken(resolve_pred_taken),
    .resolve_cond      (resolve_cond),
    .alu_result        (alu_result),
    .carry_in          (carry_in),
    .carry_we          (carry_we),
    .br_taken          (br_taken),
    .mispredict        (mispredict),
    .resolve_done      (resolve_done)
`ifdef BRP_PERF_CNT_EN
    ,
    .perf_branches     (perf_branches),
    .perf_mispred      (perf_mispred)
`endif
  );

  function automatic int idx_of(input logic [PC_W-1:0] pc);
    return int'((pc / (1 << PC_LSB)) % DEPTH);
  endfunction

  function automatic bit ref_taken(input logic [2:0] c, input logic [DATA_W-1:0] a, input bit cy);
    bit t;
    case (c)
      3'd0: t = 0;
      3'd1: t = 1;
      3'd2: t = (a == 0);
      3'd3: t = (a != 0);
      3'd4: t = ($signed(a) < 0);
      3'd5: t = ($signed(a) >= 0);
      3'd6: t = cy;
      default: t = !cy;
    endcase
    return t;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_carry    = 0;
    m_pb       = 0;
    m_pm       = 0;
    m_last_mis = 0;
  endtask

  // One clock cycle: drive, check prediction, advance edge, check verdict
  task automatic step(input bit req, input logic [PC_W-1:0] ppc, input bit rv,
                      input logic [PC_W-1:0] rpc, input bit rpt, input logic [2:0] c,
                      input logic [DATA_W-1:0] a, input bit cwe, input bit cin);
    bit exp_pt, cy, tk, mis;
    int ri;
    pred_req = req; pred_pc = ppc; resolve_valid = rv; resolve_pc = rpc;
    resolve_pred_taken = rpt; resolve_cond = c; alu_result = a;
    carry_we = cwe; carry_in = cin;
    #1;
    exp_pt = req && (m_bht[idx_of(ppc)] >= 2);
    n_vec++;
    if (pred_taken !== exp_pt) begin
      n_err++;
      $display("FAIL pred_taken pc=%h got %b want %b", ppc, pred_taken, exp_pt);
    end
    cy  = cwe ? cin : m_carry;
    tk  = rv && ref_taken(c, a, cy);
    mis = rv && (tk ^ rpt);
    @(posedge clk);
    if (rv && c >= 3'd2) begin
      ri = idx_of(rpc);
      if (tk) m_bht[ri] = (m_bht[ri] == 3) ? 3 : m_bht[ri] + 1;
      else    m_bht[ri] = (m_bht[ri] == 0) ? 0 : m_bht[ri] - 1;
    end
    if (cwe) m_carry = cin;
    if (m_last_mis) m_pm++;
    m_last_mis = mis;
    if (rv) m_pb++;
    #1;
    n_vec++;
    if (br_taken !== tk) begin
      n_err++;
      $display("FAIL br_taken cond=%0d alu=%h got %b want %b", c, a, br_taken, tk);
    end
    n_vec++;
    if (mispredict !== mis) begin
      n_err++;
      $display("FAIL mispredict cond=%0d got %b want %b", c, mispredict, mis);
    end
    n_vec++;
    if (resolve_done !== rv) begin
      n_err++;
      $display("FAIL resolve_done got %b want %b", resolve_done, rv);
    end
`ifdef BRP_PERF_CNT_EN
    n_vec++;
    if (perf_branches !== 32'(m_pb) || perf_mispred !== 32'(m_pm)) begin
      n_err++;
      $display("FAIL perf got %0d/%0d want %0d/%0d", perf_branches, perf_mispred, m_pb, m_pm);
    end
`endif
  endtask

  task automatic idle();
    step(0, '0, 0, '0, 0, 3'd0, 'x, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pred_req = 0; pred_pc = '0; resolve_valid = 0; resolve_pc = '0;
    resolve_pred_taken = 0; resolve_cond = '0; alu_result = '0;
    carry_we = 0; carry_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    n_vec++;
    if ({br_taken, mispredict, resolve_done} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 000", {br_taken, mispredict, resolve_done});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 32'h40, 0, '0, 0, 3'd0, '0, 0, 0);
  endtask

  task automatic test_train();
    // 01 -> 10 with a mispredicted taken BZ
    step(1, 32'h40, 1, 32'h40, 0, 3'd2, 16'h0000, 0, 0);
    step(1, 32'h40, 0, '0, 0, 3'd0, '0, 0, 0);
    n_vec++;
    if (pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL train_first got %b want 1", pred_taken);
    end
    repeat (3) step(1, 32'h40, 1, 32'h40, 1, 3'd2, 16'h0000, 0, 0);
    // Not-taken BNZ from saturated: 11 -> 10 -> 01
    step(1, 32'h40, 1, 32'h40, 1, 3'd3, 16'h0000, 0, 0);
    step(1, 32'h40, 1, 32'h40, 1, 3'd3, 16'h0000, 0, 0);
    step(1, 32'h40, 0, '0, 0, 3'd0, '0, 0, 0);
  endtask

  task automatic test_sign();
    step(0, '0, 1, 32'h100, 0, 3'd4, 16'h8000, 0, 0);
    step(0, '0, 1, 32'h104, 0, 3'd4, 16'h7FFF, 0, 0);
    step(0, '0, 1, 32'h108, 0, 3'd5, 16'h0000, 0, 0);
    step(0, '0, 1, 32'h10C, 1, 3'd5, 16'hFFFF, 0, 0);
  endtask

  task automatic test_carry();
    step(0, '0, 1, 32'h200, 0, 3'd6, '0, 1, 1);
    step(0, '0, 1, 32'h204, 0, 3'd7, '0, 0, 0);
    step(1, 32'h208, 1, 32'h208, 0, 3'd1, '0, 0, 0);
    step(1, 32'h208, 1, 32'h208, 1, 3'd0, '0, 0, 0);
    step(1, 32'h208, 0, '0, 0, 3'd0, '0, 1, 0);
    step(0, '0, 1, 32'h20C, 0, 3'd6, '0, 0, 0);
  endtask

  task automatic test_alias_and_reset();
    repeat (3) step(0, '0, 1, 32'h40, 0, 3'd2, 16'h0000, 0, 0);
    step(1, 32'h80, 0, '0, 0, 3'd0, '0, 0, 0);
    // Leave a taken resolve's verdict on the outputs, then reset mid-resolve
    step(1, 32'h80, 1, 32'h40, 0, 3'd1, '0, 0, 0);
    resolve_valid = 1; resolve_pc = 32'h40; resolve_cond = 3'd2; alu_result = '0;
    resolve_pred_taken = 0; carry_we = 1; carry_in = 1;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({br_taken, mispredict, resolve_done} !== 3'b000) begin
      n_err++;
      $display("FAIL async_reset got %b want 000", {br_taken, mispredict, resolve_done});
    end
    model_reset();
    @(posedge clk); #1;
    resolve_valid = 0; carry_we = 0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step(1, 32'h40, 0, '0, 0, 3'd0, '0, 0, 0);
    step(0, '0, 1, 32'h300, 0, 3'd6, '0, 0, 0);
  endtask

  task automatic test_random();
    logic [PC_W-1:0] pcs [4];
    pcs[0] = 32'h40; pcs[1] = 32'h80; pcs[2] = 32'h44; pcs[3] = 32'h1234;
    for (int n = 0; n < 400; n++) begin
      bit rv;
      logic [DATA_W-1:0] a;
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: a = '0;
        1: a = 16'h8000;
        2: a = DATA_W'($urandom);
        default: a = 16'h7FFF;
      endcase
      if (!rv) a = 'x;
      step($urandom_range(0, 1), pcs[$urandom_range(0, 3)], rv, pcs[$urandom_range(0, 3)],
           $urandom_range(0, 1), rv ? 3'($urandom_range(0, 7)) : 3'bxxx, a,
           $urandom_range(0, 1), $urandom_range(0, 1));
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_train();
    test_sign();
    test_carry();
    test_alias_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
Parametrised branch unit for the KGP miniRISC pipeline. It generalises the combinational branch decider: 8 condition codes, a DATA_W-wide zero/sign test, and a registered carry flag. It adds a DEPTH-entry 2-bit saturating-counter branch history table (BHT). Fetch queries predictions; execute resolves branches and receives a registered taken/mispredict verdict one cycle later.

Parameters:
DATA_W, 32, ALU result width (>=2)
PC_W, 32, program counter width
DEPTH, 16, BHT entries; power of two, >=2
PC_LSB, 2, lowest PC bit used for indexing (word-aligned PCs)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pred_req  in  1  fetch lookup request
pred_pc  in  PC_W  PC being fetched
pred_taken  out  1  combinational prediction: pred_req & BHT[idx(pred_pc)][1]
resolve_valid  in  1  branch resolving this cycle
resolve_pc  in  PC_W  PC of the resolving branch
resolve_pred_taken  in  1  prediction carried down the pipe with the branch
resolve_cond  in  3  condition code
alu_result  in  DATA_W  operand tested for zero/sign
carry_in  in  1  new carry flag value
carry_we  in  1  carry flag write enable
br_taken  out  1  registered actual outcome
mispredict  out  1  registered pulse: outcome differs from prediction
resolve_done  out  1  registered copy of resolve_valid

Behaviour:
- idx(pc) = pc[PC_LSB+IDX_W-1:PC_LSB], with IDX_W = $clog2(DEPTH). Aliasing PCs share an entry.
- Condition codes:
  - 000 NEVER
  - 001 ALWAYS
  - 010 BZ: alu_result==0
  - 011 BNZ
  - 100 BLTZ: alu_result[DATA_W-1]
  - 101 BGEZ
  - 110 BCY: carry
  - 111 BNCY
- Carry source: when carry_we=1 in the resolve cycle, carry_in is bypassed into the evaluation. Otherwise the registered carry flag is used. The flag register loads carry_in on any edge with carry_we=1.
- Latency: outcome is computed combinationally in the resolve cycle and registered. br_taken, mispredict and resolve_done are valid the following cycle.
- They are single-cycle pulses and are 0 in any cycle not following resolve_valid.
- mispredict = taken XOR resolve_pred_taken, and applies to all 8 codes.
- BHT update happens at the same edge, for conditional codes (010-111) only.
  - taken: counter increments, saturating at 11.
  - not taken: counter decrements, saturating at 00.
  - NEVER/ALWAYS leave the BHT untouched.
- Same-cycle pred_req and update to the same index: pred_taken shows the pre-update value. There is no bypass.
- Reset (asynchronous, any time, including mid-resolve):
  - all BHT entries go to 01 (weakly not-taken);
  - carry flag = 0;
  - br_taken = mispredict = resolve_done = 0.
  - pred_taken is 0 while pred_req=0.
  - A resolve in flight when reset asserts is discarded.
- resolve_valid=0: no state change except the carry write.
- X on alu_result/resolve_cond while resolve_valid=0 must not propagate into state.

Optional Feature:
BRP_PERF_CNT_EN
- Defined: adds outputs perf_branches[31:0] and perf_mispred[31:0].
  - Each increments on every resolve_valid and every registered mispredict respectively.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package br_pkg holds:
  - the cond_e enum (3-bit codes above);
  - counter constants: SNT=00, WNT=01, WT=10, ST=11, and BHT_RESET=WNT;
  - a helper function sat_next(ctr, taken).
- One natural sub-module: br_cond_eval.
  - Combinational; parametrised by DATA_W.
  - Inputs: cond, alu_result, carry. Output: taken.
  - Directly replaces the old decider.

Test Plan:
1. Reset, then pred_req=1, pred_pc=0x40 -> pred_taken=0; br_taken=mispredict=resolve_done=0.
2. resolve pc=0x40, cond=BZ, alu_result=0, pred_taken=0 -> next cycle br_taken=1, mispredict=1, resolve_done=1; pred_pc=0x40 now gives pred_taken=1 (01->10).
3. Three more taken BZ at 0x40 -> counter saturates at 11. Then BNZ with alu_result=0 (not taken, pred 1) -> mispredict=1, counter 10, pred_taken still 1. A second not-taken -> counter 01, pred_taken=0.
4. DATA_W=16:
   - BLTZ with alu_result=0x8000 -> br_taken=1.
   - BLTZ with 0x7FFF -> br_taken=0.
   - BGEZ with 0x0000 -> br_taken=1.
5. carry_we=1, carry_in=1 in the same cycle as BCY -> br_taken=1 (bypass). Next cycle, BNCY with carry_we=0 -> br_taken=0. ALWAYS with pred 0 -> mispredict=1 and BHT unchanged.
6. DEPTH=16: train 0x40 to 11, then pred_pc=0x80 (aliases idx 0) -> pred_taken=1. Assert rst_n=0 during a resolve cycle -> outputs 0 immediately, no pulse after release, pred 0x40 = 0.
